// File: rtl/i2s_level_meter_pkg.sv
// level_meter_pkg: shared types and helpers for the I2S level meter.
// Holds the FSM state enum, magnitude width and a saturating abs.
package level_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_ACCUM
    } state_t;

    localparam int unsigned AUDIO_DW_DEF = 32;
    localparam int unsigned ABS_MAX_W    = 64;

    // Magnitude drops the sign bit.
    function automatic int unsigned mag_w(input int unsigned dw);
        return dw - 1;
    endfunction

    localparam int unsigned MAG_W_DEF = mag_w(AUDIO_DW_DEF);

    // |x| of a sample sign-extended to ABS_MAX_W bits, clamped to
    // dw-1 bits so the most-negative code maps to all-ones.
    function automatic logic [ABS_MAX_W-1:0] sat_abs(
        input logic [ABS_MAX_W-1:0] x,
        input int unsigned          dw
    );
        logic [ABS_MAX_W-1:0] m;
        logic [ABS_MAX_W-1:0] lim;
        m   = x[ABS_MAX_W-1] ? (~x + ABS_MAX_W'(1)) : x;
        lim = (ABS_MAX_W'(1) << (dw - 1)) - ABS_MAX_W'(1);
        if (m > lim) begin
            m = lim;
        end
        return m;
    endfunction

endpackage

// File: rtl/i2s_level_meter_if.sv
// i2s_level_meter_if: meter control inputs, samples and results.
// master drives enable/clear/samples; slave (the meter) drives results.
interface i2s_level_meter_if #(
    parameter int unsigned AUDIO_DW   = 32,
    parameter int unsigned CLIP_CNT_W = 16
);
    logic                  enable;
    logic                  clear;
    logic [AUDIO_DW-1:0]   left_chan;
    logic [AUDIO_DW-1:0]   right_chan;
    logic [AUDIO_DW-2:0]   left_peak;
    logic [AUDIO_DW-2:0]   right_peak;
    logic                  peak_valid;
    logic [CLIP_CNT_W-1:0] left_clip_cnt;
    logic [CLIP_CNT_W-1:0] right_clip_cnt;
    logic                  clip_flag;

    modport master (
        output enable, clear, left_chan, right_chan,
        input  left_peak, right_peak, peak_valid,
        input  left_clip_cnt, right_clip_cnt, clip_flag
    );

    modport slave (
        input  enable, clear, left_chan, right_chan,
        output left_peak, right_peak, peak_valid,
        output left_clip_cnt, right_clip_cnt, clip_flag
    );
endinterface

// File: rtl/i2s_level_meter_chan.sv
// level_meter_chan: per-channel magnitude, peak and clip counter.
// In: lrclk, rst (async low), accum_en, window_end, clear, sample.
// Out: peak, clip_cnt, clip_hit. Macro LEVEL_METER_DECAY_EN selects
// peak-hold with exponential decay instead of windowed peak.
module level_meter_chan
    import level_meter_pkg::*;
#(
    parameter int unsigned AUDIO_DW    = 32,
    parameter int unsigned CLIP_CNT_W  = 16,
    parameter int unsigned DECAY_SHIFT = 6
) (
    input  logic                  lrclk,
    input  logic                  rst,
    input  logic                  accum_en,
    input  logic                  window_end,
    input  logic                  clear,
    input  logic [AUDIO_DW-1:0]   sample,
    output logic [AUDIO_DW-2:0]   peak,
    output logic [CLIP_CNT_W-1:0] clip_cnt,
    output logic                  clip_hit
);
    localparam int unsigned MW = mag_w(AUDIO_DW);

    logic [ABS_MAX_W-1:0] x_sext;
    logic [MW-1:0]        mag;

    assign x_sext = {{(ABS_MAX_W-AUDIO_DW){sample[AUDIO_DW-1]}},
                     sample};
    assign mag    = MW'(sat_abs(x_sext, AUDIO_DW));

    // All-ones magnitude covers both +full-scale and most-negative.
    assign clip_hit = accum_en & (&mag);

`ifdef LEVEL_METER_DECAY_EN
    logic [MW-1:0] dec;
    logic [MW-1:0] nxt;

    assign dec = peak - (peak >> DECAY_SHIFT);
    assign nxt = (mag > dec) ? mag : dec;

    // window_end strobes every accumulating frame in this mode.
    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            peak <= '0;
        end else if (clear) begin
            peak <= '0;
        end else if (window_end) begin
            peak <= nxt;
        end
    end
`else
    logic [MW-1:0] run;
    logic [MW-1:0] run_max;

    assign run_max = (mag > run) ? mag : run;

    // The window's last frame folds straight into the published peak
    // so no frame is lost between windows.
    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            run  <= '0;
            peak <= '0;
        end else if (clear) begin
            run  <= '0;
            peak <= '0;
        end else if (window_end) begin
            peak <= run_max;
            run  <= '0;
        end else if (accum_en) begin
            run  <= run_max;
        end else begin
            run  <= '0;
        end
    end
`endif

    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            clip_cnt <= '0;
        end else if (clear) begin
            clip_cnt <= '0;
        end else if (clip_hit && !(&clip_cnt)) begin
            clip_cnt <= clip_cnt + CLIP_CNT_W'(1);
        end
    end

endmodule

// File: rtl/i2s_level_meter.sv
// i2s_level_meter: stereo windowed peak meter with clip counters.
// Ports: rst (async low), lrclk (one posedge per frame), bus (slave
// modport: enable, clear, left/right_chan in; peaks, peak_valid,
// clip counters, clip_flag out). Macro LEVEL_METER_DECAY_EN enables
// decaying peak-hold in place of fixed windows.
module i2s_level_meter
    import level_meter_pkg::*;
#(
    parameter int unsigned AUDIO_DW    = 32,
    parameter int unsigned WINDOW_LOG2 = 10,
    parameter int unsigned CLIP_CNT_W  = 16,
    parameter int unsigned DECAY_SHIFT = 6
) (
    input  logic               rst,
    input  logic               lrclk,
    i2s_level_meter_if.slave   bus
);
    state_t state;
    state_t state_nxt;
    logic   accum_en;
    logic   window_end;
    logic   l_hit;
    logic   r_hit;

`ifndef LEVEL_METER_DECAY_EN
    logic [WINDOW_LOG2-1:0] cnt;
`endif

    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // SKIP drops the first frame after enable: the receiver's
    // registers may still hold a stale or partial word.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  state_nxt = bus.enable ? ST_SKIP : ST_IDLE;
            ST_SKIP:  state_nxt = bus.enable ? ST_ACCUM : ST_IDLE;
            ST_ACCUM: state_nxt = bus.enable ? ST_ACCUM : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Dropping enable in ACCUM means the frame is not metered; the
    // running peak and counter then clear as IDLE is entered.
    always_comb begin
        accum_en = (state == ST_ACCUM) && bus.enable;
`ifdef LEVEL_METER_DECAY_EN
        window_end = accum_en;
`else
        window_end = accum_en && (&cnt);
`endif
    end

`ifndef LEVEL_METER_DECAY_EN
    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clear_or_idle(bus.clear, accum_en, window_end)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + WINDOW_LOG2'(1);
        end
    end

    function automatic logic clear_or_idle(
        input logic clr,
        input logic acc,
        input logic wend
    );
        return clr || !acc || wend;
    endfunction
`endif

    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            bus.peak_valid <= 1'b0;
        end else if (bus.clear) begin
            bus.peak_valid <= 1'b0;
        end else begin
            bus.peak_valid <= window_end;
        end
    end

    always_ff @(posedge lrclk or negedge rst) begin
        if (!rst) begin
            bus.clip_flag <= 1'b0;
        end else if (bus.clear) begin
            bus.clip_flag <= 1'b0;
        end else if (l_hit || r_hit) begin
            bus.clip_flag <= 1'b1;
        end
    end

    level_meter_chan #(
        .AUDIO_DW    (AUDIO_DW),
        .CLIP_CNT_W  (CLIP_CNT_W),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_left (
        .lrclk      (lrclk),
        .rst        (rst),
        .accum_en   (accum_en),
        .window_end (window_end),
        .clear      (bus.clear),
        .sample     (bus.left_chan),
        .peak       (bus.left_peak),
        .clip_cnt   (bus.left_clip_cnt),
        .clip_hit   (l_hit)
    );

    level_meter_chan #(
        .AUDIO_DW    (AUDIO_DW),
        .CLIP_CNT_W  (CLIP_CNT_W),
        .DECAY_SHIFT (DECAY_SHIFT)
    ) u_right (
        .lrclk      (lrclk),
        .rst        (rst),
        .accum_en   (accum_en),
        .window_end (window_end),
        .clear      (bus.clear),
        .sample     (bus.right_chan),
        .peak       (bus.right_peak),
        .clip_cnt   (bus.right_clip_cnt),
        .clip_hit   (r_hit)
    );

endmodule

// File: tb/tb_i2s_level_meter.sv
// tb_i2s_level_meter: directed test of i2s_level_meter with
// WINDOW_LOG2=2, CLIP_CNT_W=4 (decay path under LEVEL_METER_DECAY_EN).
module tb_i2s_level_meter;
    import level_meter_pkg::*;

    logic rst;
    logic lrclk;
    int   passes;
    int   fails;
    int   total;

    i2s_level_meter_if #(.AUDIO_DW(32), .CLIP_CNT_W(4)) bus ();

    i2s_level_meter #(
        .AUDIO_DW    (32),
        .WINDOW_LOG2 (2),
        .CLIP_CNT_W  (4),
        .DECAY_SHIFT (1)
    ) dut (
        .rst   (rst),
        .lrclk (lrclk),
        .bus   (bus)
    );

    initial lrclk = 1'b0;
    always #5 lrclk = ~lrclk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] l, input logic [31:0] r);
        bus.left_chan  = l;
        bus.right_chan = r;
        @(posedge lrclk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_lpk"}, 64'(bus.left_peak), 64'h0);
        chk({tag, "_rpk"}, 64'(bus.right_peak), 64'h0);
        chk({tag, "_pv"}, 64'(bus.peak_valid), 64'h0);
        chk({tag, "_lcc"}, 64'(bus.left_clip_cnt), 64'h0);
        chk({tag, "_rcc"}, 64'(bus.right_clip_cnt), 64'h0);
        chk({tag, "_flag"}, 64'(bus.clip_flag), 64'h0);
    endtask

    initial begin
        passes = 0;
        fails  = 0;
        total  = 0;
        bus.enable     = 1'b0;
        bus.clear      = 1'b0;
        bus.left_chan  = '0;
        bus.right_chan = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #11;
        chk_zero("por");
        chk("por_state", 64'(dut.state), 64'(ST_IDLE));
        rst = 1'b1;
        @(posedge lrclk);
        #1;

`ifdef LEVEL_METER_DECAY_EN
        bus.enable = 1'b1;
        step(32'h0, 32'h0);
        step(32'h0, 32'h0);
        step(32'h1000, 32'h0);
        chk("dec_pk0", 64'(bus.left_peak), 64'h1000);
        chk("dec_pv0", 64'(bus.peak_valid), 64'h1);
        step(32'h0, 32'h0);
        chk("dec_pk1", 64'(bus.left_peak), 64'h800);
        chk("dec_pv1", 64'(bus.peak_valid), 64'h1);
        step(32'h0, 32'h0);
        chk("dec_pk2", 64'(bus.left_peak), 64'h400);
        chk("dec_pv2", 64'(bus.peak_valid), 64'h1);
        chk("dec_rpk", 64'(bus.right_peak), 64'h0);
        step(32'h8000_0000, 32'h0);
        chk("dec_clip_pk", 64'(bus.left_peak), 64'h7FFF_FFFF);
        chk("dec_lcc", 64'(bus.left_clip_cnt), 64'h1);
        chk("dec_flag", 64'(bus.clip_flag), 64'h1);
        bus.enable = 1'b0;
        step(32'h0, 32'h0);
        chk("dec_off_pv", 64'(bus.peak_valid), 64'h0);
        chk("dec_hold", 64'(bus.left_peak), 64'h7FFF_FFFF);
`else
        // first window, skip frame discarded
        bus.enable = 1'b1;
        step(32'h0, 32'h0);
        step(32'h7FFF_FFFF, 32'h0);
        step(32'h10, 32'h0);
        step(32'hFFFF_FF00, 32'h0);
        step(32'h80, 32'h0);
        chk("w1_early_pv", 64'(bus.peak_valid), 64'h0);
        step(32'h1, 32'h0);
        chk("w1_lpk", 64'(bus.left_peak), 64'h100);
        chk("w1_pv", 64'(bus.peak_valid), 64'h1);
        chk("w1_lcc", 64'(bus.left_clip_cnt), 64'h0);
        chk("w1_flag", 64'(bus.clip_flag), 64'h0);

        // clipping window
        step(32'h8000_0000, 32'h0);
        chk("w2_pv_drop", 64'(bus.peak_valid), 64'h0);
        chk("w2_lpk_hold", 64'(bus.left_peak), 64'h100);
        chk("w2_lcc1", 64'(bus.left_clip_cnt), 64'h1);
        step(32'h7FFF_FFFF, 32'h0);
        step(32'h7FFF_FFFE, 32'h0);
        step(32'h0, 32'h0);
        chk("w2_lpk", 64'(bus.left_peak), 64'h7FFF_FFFF);
        chk("w2_pv", 64'(bus.peak_valid), 64'h1);
        chk("w2_lcc", 64'(bus.left_clip_cnt), 64'h2);
        chk("w2_flag", 64'(bus.clip_flag), 64'h1);
        chk("w2_rpk", 64'(bus.right_peak), 64'h0);
        chk("w2_rcc", 64'(bus.right_clip_cnt), 64'h0);

        // right clip counter saturation
        for (int i = 1; i <= 20; i++) begin
            step(32'h0, 32'h7FFF_FFFF);
            if (i == 15) begin
                chk("sat_15", 64'(bus.right_clip_cnt), 64'hF);
            end
        end
        chk("sat_20", 64'(bus.right_clip_cnt), 64'hF);
        chk("sat_rpk", 64'(bus.right_peak), 64'h7FFF_FFFF);
        chk("sat_lpk", 64'(bus.left_peak), 64'h0);
        chk("sat_pv", 64'(bus.peak_valid), 64'h1);
        chk("sat_lcc", 64'(bus.left_clip_cnt), 64'h2);

        // async reset mid-run, no clock edge needed
        rst = 1'b0;
        #2;
        chk_zero("arst");
        chk("arst_state", 64'(dut.state), 64'(ST_IDLE));
        bus.enable = 1'b0;
        #1 rst = 1'b1;
        step(32'h0, 32'h0);

        // enable dropped on window-end edge
        bus.enable = 1'b1;
        step(32'h0, 32'h0);
        step(32'h0, 32'h0);
        step(32'h50, 32'h0);
        step(32'h60, 32'h0);
        step(32'h70, 32'h0);
        bus.enable = 1'b0;
        step(32'h80, 32'h0);
        chk("drop_pv", 64'(bus.peak_valid), 64'h0);
        chk("drop_lpk", 64'(bus.left_peak), 64'h0);
        chk("drop_state", 64'(dut.state), 64'(ST_IDLE));

        // clear on window-end edge
        bus.enable = 1'b1;
        step(32'h0, 32'h0);
        step(32'h0, 32'h0);
        step(32'h7FFF_FFFF, 32'h20);
        chk("clr_pre_lcc", 64'(bus.left_clip_cnt), 64'h1);
        chk("clr_pre_flag", 64'(bus.clip_flag), 64'h1);
        step(32'h5, 32'h3);
        step(32'h6, 32'h4);
        bus.clear = 1'b1;
        step(32'h100, 32'h200);
        bus.clear = 1'b0;
        chk_zero("clr");
        step(32'h11, 32'hFFFF_FFF0);
        step(32'h22, 32'h5);
        step(32'h3, 32'h30);
        step(32'h4, 32'h1);
        chk("clr_nx_lpk", 64'(bus.left_peak), 64'h22);
        chk("clr_nx_rpk", 64'(bus.right_peak), 64'h30);
        chk("clr_nx_pv", 64'(bus.peak_valid), 64'h1);
        chk("clr_nx_flag", 64'(bus.clip_flag), 64'h0);
        bus.enable = 1'b0;
        step(32'h7FFF_FFFF, 32'h0);
        chk("off_pv", 64'(bus.peak_valid), 64'h0);
        chk("off_lpk", 64'(bus.left_peak), 64'h22);
        chk("off_lcc", 64'(bus.left_clip_cnt), 64'h0);
`endif

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/i2s_level_meter.md
Name: i2s_level_meter

Overview:
- Audio level meter downstream of the I2S receiver.
- Clocked by lrclk, one edge per stereo frame. Each edge it samples the receiver's parallel left/right words.
- Produces per-channel windowed peak magnitude, a valid strobe per window, and saturating clip counters.
- Output feeds status registers / VU display logic.

Parameters:
- AUDIO_DW, 32, sample width; signed two's complement.
- WINDOW_LOG2, 10, peak window length = 2^WINDOW_LOG2 frames.
- CLIP_CNT_W, 16, clip counter width.
- DECAY_SHIFT, 6, decay rate; used only with LEVEL_METER_DECAY_EN.

Ports:
- rst, input, 1, reset: asynchronous, active-low.
- lrclk, input, 1, clock: frame clock; all logic on posedge.
- enable, input, 1, synchronous metering enable.
- clear, input, 1, synchronous clear of peaks and counters.
- left_chan, input, AUDIO_DW, left sample from receiver; stable at posedge lrclk.
- right_chan, input, AUDIO_DW, right sample from receiver; stable at posedge lrclk.
- left_peak, output, AUDIO_DW-1, left window peak magnitude.
- right_peak, output, AUDIO_DW-1, right window peak magnitude.
- peak_valid, output, 1, one-cycle pulse when the peaks update.
- left_clip_cnt, output, CLIP_CNT_W, saturating left clip count.
- right_clip_cnt, output, CLIP_CNT_W, saturating right clip count.
- clip_flag, output, 1, sticky: any clip since reset/clear.

Behaviour:
- Reset (rst=0, async): all outputs 0, internal running peaks 0, frame counter 0, state IDLE.
- Magnitude:
  - mag = |x| as unsigned AUDIO_DW-1 bits.
  - Most-negative input (1 followed by all zeros) saturates to all-ones.
- Clip:
  - A frame clips per channel when mag == all-ones (covers +full-scale and most-negative).
  - Each clipping frame increments that channel's counter, saturating at 2^CLIP_CNT_W-1, and sets clip_flag.
  - Clip detection happens only in ACCUM.
- FSM:
  - IDLE: enable=1 -> SKIP.
  - SKIP: discards one frame, because receiver registers may be stale/partial. Next edge -> ACCUM if enable=1, else IDLE.
  - ACCUM: each edge, run_x <= max(run_x, mag_x) and cnt++. enable=0 -> IDLE.
  - Entering IDLE from any state clears run_x and cnt; outputs hold their values.
- Window end (ACCUM edge with cnt == 2^WINDOW_LOG2-1):
  - x_peak <= max(run_x, mag_x); peak_valid <= 1; run_x <= 0; cnt <= 0.
  - peak_valid is 1 for exactly the following lrclk period, otherwise 0. No frame is lost between windows.
- clear=1 on an edge:
  - Zeros run_x, cnt, x_peak, clip counters and clip_flag; peak_valid <= 0. State unchanged.
  - clear wins over a simultaneous window end or clip.
- enable dropped on the window-end edge: IDLE entered, no peak update, peak_valid stays 0.
- Latency: sample to peak output is 1 lrclk edge after the window's last frame.

Optional Feature:
- Macro LEVEL_METER_DECAY_EN.
- Defined:
  - Windowing is replaced by peak-hold with exponential decay.
  - Every ACCUM edge: x_peak <= max(mag_x, x_peak - (x_peak >> DECAY_SHIFT)); peak_valid <= 1.
  - cnt and run_x are not implemented; WINDOW_LOG2 is ignored.
  - IDLE/SKIP hold x_peak with peak_valid=0.
  - Clip logic and clear are unchanged.
- Undefined: windowed behaviour as above; DECAY_SHIFT is ignored.

Decomposition:
- Package level_meter_pkg holds:
  - the state enum (IDLE, SKIP, ACCUM);
  - the magnitude width constant, derived from AUDIO_DW;
  - a saturating-abs function.
- Sub-module level_meter_chan, instantiated twice (left/right), contains:
  - abs/saturation;
  - running peak;
  - output peak (or decay);
  - clip detect;
  - clip counter.
  It takes accum_en, window_end and clear from the top.
- The top holds the FSM, frame counter, peak_valid and the clip_flag OR.

Test Plan (WINDOW_LOG2=2, CLIP_CNT_W=4, AUDIO_DW=32):
1. rst=0 mid-run, with nonzero peaks and counters -> all outputs 0 immediately, without an lrclk edge; FSM in IDLE.
2. enable=1; frames: skip frame 0x7FFFFFFF, then L = 0x10, 0xFFFFFF00, 0x80, 0x1 -> left_peak=0x100 with a single-cycle peak_valid; the skipped frame is not counted and left_clip_cnt=0.
3. L = 0x80000000, then 0x7FFFFFFF, 0x7FFFFFFE, 0 -> left_peak=0x7FFFFFFF, left_clip_cnt=2, clip_flag=1; right channel unaffected.
4. 20 consecutive clipping frames on the right channel -> right_clip_cnt reaches 15 and stays 15.
5. clear=1 on the window-end edge -> peak_valid stays 0, peaks/counters/clip_flag are 0, and the next full window reports correctly.
6. With LEVEL_METER_DECAY_EN, DECAY_SHIFT=1: L = 0x1000 then zeros -> left_peak sequence 0x1000, 0x800, 0x400, with peak_valid=1 each frame.
